// File: rtl/zbus_pkg.sv
// Shared helpers for the zbus FIFO family: pointer wrap-increment, threshold
// compare and pointer-width derivation.
package zbus_pkg;

   // Pointer increment that wraps from len-1 back to 0; len need not be a power of two.
   function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned len);
      return (ptr >= len - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

   function automatic logic at_or_below(input int unsigned val, input int unsigned thr);
      return val <= thr;
   endfunction

   function automatic int unsigned ptr_width(input int unsigned len);
      return (len > 32'd1) ? $clog2(len) : 32'd1;
   endfunction

endpackage

// File: rtl/zbus_fifo_mem.sv
// LN x BW storage for the zbus FIFOs: one synchronous write port and one
// asynchronous read port.
module zbus_fifo_mem #(
   parameter int BW  = 8,
   parameter int LN  = 4,
   parameter int LNL = 2
) (
   input  logic           clk,
   input  logic           i_we,
   input  logic [LNL-1:0] i_waddr,
   input  logic [BW-1:0]  i_wdata,
   input  logic [LNL-1:0] i_raddr,
   output logic [BW-1:0]  o_rdata
);

   logic [BW-1:0] r_mem [LN];

   // NOTE: storage carries no reset; control state alone decides which words are valid.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/zbus_fifo_reg_sync.sv
// Single-clock valid/ack FIFO with registered count and thresholds.
// Define ZBUS_FIFO_BYPASS_EN to let a word pass straight through when empty.
module zbus_fifo_reg_sync
   import zbus_pkg::*;
#(
   parameter  int BW  = 8,
   parameter  int LN  = 4,
   parameter  int AFL = 1,
   parameter  int AEL = 1,
   localparam int LNL = ptr_width(LN),
   localparam int CNL = $clog2(LN + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           zi_vld,
   input  logic [BW-1:0]  zi_bus,
   output logic           zi_ack,
   output logic [CNL-1:0] zi_num,
   output logic           zi_afl,
   output logic           zo_vld,
   output logic [BW-1:0]  zo_bus,
   input  logic           zo_ack,
   output logic [CNL-1:0] zo_num,
   output logic           zo_ael
);

   logic [LNL-1:0] r_wpb;
   logic [LNL-1:0] r_rpb;
   logic [CNL-1:0] r_cnt;

   logic           w_zi_trn;
   logic           w_zo_trn;
   logic           w_we;
   logic           w_rd;
   logic [BW-1:0]  w_mem_rd;

   assign zi_ack   = (r_cnt < CNL'(LN)) & ~clr;
   assign w_zi_trn = zi_vld & zi_ack;
   assign w_zo_trn = zo_vld & zo_ack;

`ifdef ZBUS_FIFO_BYPASS_EN
   logic w_byp;

   // An empty FIFO presents the incoming word directly; if taken, it is never stored.
   assign w_byp  = (r_cnt == '0) & zi_vld & ~clr;
   assign zo_vld = ((r_cnt != '0) & ~clr) | w_byp;
   assign zo_bus = w_byp ? zi_bus : w_mem_rd;
   assign w_we   = w_zi_trn & ~(w_byp & zo_ack);
   assign w_rd   = w_zo_trn & ~w_byp;
`else
   assign zo_vld = (r_cnt != '0) & ~clr;
   assign zo_bus = w_mem_rd;
   assign w_we   = w_zi_trn;
   assign w_rd   = w_zo_trn;
`endif

   assign zo_num = r_cnt;
   assign zi_num = CNL'(LN) - r_cnt;
   assign zi_afl = at_or_below(32'(zi_num), AFL);
   assign zo_ael = at_or_below(32'(r_cnt), AEL);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wpb <= '0;
         r_rpb <= '0;
         r_cnt <= '0;
      end else if (clr) begin
         r_wpb <= '0;
         r_rpb <= '0;
         r_cnt <= '0;
      end else begin
         if (w_we) r_wpb <= LNL'(wrap_inc(32'(r_wpb), LN));
         if (w_rd) r_rpb <= LNL'(wrap_inc(32'(r_rpb), LN));
         case ({w_we, w_rd})
            2'b10:   r_cnt <= r_cnt + CNL'(1);
            2'b01:   r_cnt <= r_cnt - CNL'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   zbus_fifo_mem #(
      .BW  (BW),
      .LN  (LN),
      .LNL (LNL)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_wpb),
      .i_wdata (zi_bus),
      .i_raddr (r_rpb),
      .o_rdata (w_mem_rd)
   );

endmodule

// File: tb/tb_zbus_fifo_reg_sync.sv
// Scoreboard bench for zbus_fifo_reg_sync (LN=3): directed stimulus pushes
// accepted words, a monitor pops and compares on every read transfer.
module tb_zbus_fifo_reg_sync;

   localparam int BW  = 8;
   localparam int LN  = 3;
   localparam int AFL = 1;
   localparam int AEL = 1;
   localparam int CNL = $clog2(LN + 1);
`ifdef ZBUS_FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           clr;
   logic           zi_vld;
   logic [BW-1:0]  zi_bus;
   logic           zi_ack;
   logic [CNL-1:0] zi_num;
   logic           zi_afl;
   logic           zo_vld;
   logic [BW-1:0]  zo_bus;
   logic           zo_ack;
   logic [CNL-1:0] zo_num;
   logic           zo_ael;

   int n_cmp = 0;
   int n_err = 0;
   int mdl_cnt = 0;
   logic [BW-1:0] exp_q[$];

   always #5 clk = ~clk;

   zbus_fifo_reg_sync #(
      .BW  (BW),
      .LN  (LN),
      .AFL (AFL),
      .AEL (AEL)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .zi_vld (zi_vld),
      .zi_bus (zi_bus),
      .zi_ack (zi_ack),
      .zi_num (zi_num),
      .zi_afl (zi_afl),
      .zo_vld (zo_vld),
      .zo_bus (zo_bus),
      .zo_ack (zo_ack),
      .zo_num (zo_num),
      .zo_ael (zo_ael)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every read transfer must deliver the oldest outstanding word.
   initial begin
      forever begin
         @(negedge clk);
         if (zo_vld === 1'b1 && zo_ack === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_read", {24'd0, zo_bus}, 32'hDEAD);
            else check("rd_data", {24'd0, zo_bus}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   // One clock of stimulus; the bench model predicts status and acceptance.
   task automatic cycle(input logic vld, input logic [BW-1:0] bus, input logic ack,
                        input logic c, input logic r);
      bit wr, rd, ev;
      rst = r; clr = c; zi_vld = vld; zi_bus = bus; zo_ack = ack;
      wr = !c && vld && (mdl_cnt < LN);
      ev = !c && (mdl_cnt != 0 || (BYP && vld));
      rd = ack && ev;
      if (wr && !r) exp_q.push_back(bus);
      @(negedge clk);
      check("zi_ack", {31'd0, zi_ack}, {31'd0, wr || (!c && mdl_cnt < LN)});
      check("zo_vld", {31'd0, zo_vld}, {31'd0, ev});
      check("zo_num", 32'(zo_num), 32'(mdl_cnt));
      check("zi_num", 32'(zi_num), 32'(LN - mdl_cnt));
      check("zi_afl", {31'd0, zi_afl}, {31'd0, (LN - mdl_cnt) <= AFL});
      check("zo_ael", {31'd0, zo_ael}, {31'd0, mdl_cnt <= AEL});
      @(posedge clk);
      #1;
      if (r || c) begin
         mdl_cnt = 0;
         exp_q.delete();
      end else begin
         mdl_cnt = mdl_cnt + int'(wr) - int'(rd);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int guard;
      rst = 1'b1; clr = 1'b0; zi_vld = 1'b0; zi_bus = '0; zo_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_zi_ack", {31'd0, zi_ack}, 32'd1);
      check("rst_zo_vld", {31'd0, zo_vld}, 32'd0);
      check("rst_zi_num", 32'(zi_num), 32'd3);
      check("rst_zo_num", 32'(zo_num), 32'd0);
      check("rst_zi_afl", {31'd0, zi_afl}, 32'd0);
      check("rst_zo_ael", {31'd0, zo_ael}, 32'd1);
      @(posedge clk);
      #1;

      // Fill to full, then a 4th write is refused
      cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
      check("full_zi_ack", {31'd0, zi_ack}, 32'd0);
      check("full_zi_num", 32'(zi_num), 32'd0);
      check("full_zo_num", 32'(zo_num), 32'd3);
      check("full_zi_afl", {31'd0, zi_afl}, 32'd1);
      cycle(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);

      // Full with simultaneous vld/ack: read only
      cycle(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0);
      check("after_full_rw_cnt", 32'(zo_num), 32'd2);
      check("after_full_rw_ack", {31'd0, zi_ack}, 32'd1);

      // Flush at cnt=2 overrides transfers
      cycle(1'b1, 8'hB1, 1'b1, 1'b1, 1'b0);
      check("clr_cnt", 32'(zo_num), 32'd0);
      check("clr_zo_vld", {31'd0, zo_vld}, 32'd0);
      check("clr_zi_num", 32'(zi_num), 32'd3);

      // Continuous stream of 10 words, pointers wrap several times
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0, 1'b0);
      guard = 0;
      while (mdl_cnt > 0 && guard < 10) begin
         cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         guard++;
      end

      // Reset mid-stream discards stored words
      cycle(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hD2, 1'b0, 1'b0, 1'b0);
      check("pre_rst_cnt", 32'(zo_num), 32'd2);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("post_rst_cnt", 32'(zo_num), 32'd0);
      check("post_rst_zi_ack", {31'd0, zi_ack}, 32'd1);
      check("post_rst_zo_vld", {31'd0, zo_vld}, 32'd0);
      cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Empty with vld/ack: bypass passes through, otherwise one cycle latency
      cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
      check("byp_cnt", 32'(zo_num), BYP ? 32'd0 : 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Mixed pattern with stalls
      cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);

      guard = 0;
      while (mdl_cnt > 0 && guard < 10) begin
         cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         guard++;
      end
      check("drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
